// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage sitting in front of the instruction memory.
//
// The block owns the program counter and drives it onto the instruction memory address.
// The word that comes back is captured into the IF/ID register. Supported actions are
// sequential fetch, stall, branch and jump redirects (each inserts a bubble), and a
// sticky address-error flag. A fetch counter is kept for test benches.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            asynchronous active-low reset
//   pc_addr_o [31:0] current PC, feeds the instruction memory address
//   instr_i   [31:0] instruction memory read data for pc_addr_o (combinational)
//   stall_i          hold PC, IF/ID and the fetch counter
//   branch_taken_i   redirect to branch_target_i (highest priority)
//   branch_target_i  branch destination byte address
//   jump_i           redirect to the jump target taken from the IF/ID instruction
//   instr_o   [31:0] IF/ID instruction
//   pc_plus4_o[31:0] IF/ID PC+4 belonging to instr_o
//   valid_o          IF/ID holds a real instruction (0 = bubble)
//   fetch_cnt_o      number of instructions accepted into IF/ID
//   addr_err_o       sticky address-error flag
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_addr_o,
  input  logic [31:0] instr_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic [31:0] fetch_cnt_o,
  output logic        addr_err_o
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  // The limit is 33 bits wide so that it cannot overflow for any legal MEM_WORDS.
  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

  logic [31:0] pc;
  ifid_t       ifid;
  logic [31:0] fetch_cnt;
  logic        addr_err;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] next_pc;
  logic        do_branch, do_jump, flush, advance, pc_load;
  logic        misalign, out_of_range;

  assign pc_plus4    = pc + 32'd4;
  assign jump_target = {ifid.pc_plus4[31:28], ifid.instr[25:0], 2'b00};

  // Priority order: branch, then jump, then stall, then sequential fetch.
  always_comb begin
    do_branch    = branch_taken_i;
    do_jump      = !branch_taken_i && jump_i;
    flush        = do_branch || do_jump;
    advance      = !flush && !stall_i;
    pc_load      = flush || advance;
    next_pc      = pc_plus4;
    misalign     = 1'b0;
    if (do_branch) begin
      next_pc  = {branch_target_i[31:2], 2'b00};
      misalign = |branch_target_i[1:0];
    end else if (do_jump) begin
      next_pc = jump_target;
    end
    out_of_range = ({1'b0, next_pc} >= PC_LIMIT);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc        <= RESET_PC;
      ifid      <= '0;
      fetch_cnt <= '0;
      addr_err  <= 1'b0;
    end else begin
      if (pc_load) pc <= next_pc;
      if (flush) begin
        ifid <= '0;
      end else if (advance) begin
        ifid.instr    <= instr_i;
        ifid.pc_plus4 <= pc_plus4;
        ifid.valid    <= 1'b1;
      end
      if (advance) fetch_cnt <= fetch_cnt + 32'd1;
      // The PC is loaded even when it is bad. Only the flag records the problem.
      if (pc_load && (misalign || out_of_range)) addr_err <= 1'b1;
    end
  end

  assign pc_addr_o   = pc;
  assign instr_o     = ifid.instr;
  assign pc_plus4_o  = ifid.pc_plus4;
  assign valid_o     = ifid.valid;
  assign fetch_cnt_o = fetch_cnt;
  assign addr_err_o  = addr_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int MEM_WORDS = 32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_addr_o, instr_i;
  logic        stall_i, branch_taken_i, jump_i;
  logic [31:0] branch_target_i;
  logic [31:0] instr_o, pc_plus4_o, fetch_cnt_o;
  logic        valid_o, addr_err_o;

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(MEM_WORDS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_addr_o(pc_addr_o), .instr_i(instr_i),
    .stall_i(stall_i), .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .instr_o(instr_o), .pc_plus4_o(pc_plus4_o), .valid_o(valid_o),
    .fetch_cnt_o(fetch_cnt_o), .addr_err_o(addr_err_o)
  );

  always #5 clk_i = ~clk_i;

  // The memory model has 64 backing words. Addresses beyond that return a value
  // derived from the address.
  logic [31:0] mem [64];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:2]];
    return a ^ 32'hA5A5_0000;
  endfunction
  always_comb begin
    if (pc_addr_o < 32'd256) instr_i = mem[pc_addr_o[7:2]];
    else                     instr_i = pc_addr_o ^ 32'hA5A5_0000;
  end

  int checks = 0;
  int failures = 0;

  // Reference model of the architectural state.
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_err;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_cnt = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    pc_addr_o,            m_pc);
    chk({tag, ".instr"}, instr_o,              m_instr);
    chk({tag, ".pc4"},   pc_plus4_o,           m_pc4);
    chk({tag, ".valid"}, {31'b0, valid_o},     {31'b0, m_valid});
    chk({tag, ".cnt"},   fetch_cnt_o,          m_cnt);
    chk({tag, ".err"},   {31'b0, addr_err_o},  {31'b0, m_err});
  endtask

  // Apply one clock edge with the inputs that are currently driven, then compare.
  task automatic step(input string tag);
    logic [31:0] npc;
    logic        load;
    load = 1'b1;
    npc  = m_pc;
    if (branch_taken_i) begin
      npc = branch_target_i & ~32'h3;
      if (branch_target_i[1:0] != 2'b00) m_err = 1'b1;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (jump_i) begin
      npc = {m_pc4[31:28], m_instr[25:0], 2'b00};
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (stall_i) begin
      load = 1'b0;
    end else begin
      npc = m_pc + 32'd4;
      m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_cnt = m_cnt + 32'd1;
    end
    if (load) begin
      if (64'(npc) >= 64'(MEM_WORDS) * 4) m_err = 1'b1;
      m_pc = npc;
    end
    @(posedge clk_i); #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic br, input logic [31:0] bt, input logic jp, input logic st);
    branch_taken_i = br; branch_target_i = bt; jump_i = jp; stall_i = st;
  endtask

  // Reset asserted between clock edges. It must act without waiting for an edge.
  task automatic mid_reset(input string tag);
    #2 rst_i = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(negedge clk_i) rst_i = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
    set_in(0, 0, 0, 0);
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    #1 model_reset();
    check_all("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b1;

    // Sequential fetch.
    for (int i = 0; i < 4; i++) step("seq");
    chk("seq.pc_const",  pc_addr_o,   32'd16);
    chk("seq.ins_const", instr_o,     32'h1000_0003);
    chk("seq.cnt_const", fetch_cnt_o, 32'd4);

    // Stall while PC=8.
    mid_reset("rst2");
    step("pre"); step("pre");
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall.pc_const", pc_addr_o, 32'd8);
    set_in(0, 0, 0, 0);
    step("release");
    chk("release.pc_const", pc_addr_o, 32'd12);

    // A branch wins over a simultaneous stall and jump.
    set_in(1, 32'h14, 1, 1);
    step("br");
    chk("br.pc_const", pc_addr_o, 32'h14);
    set_in(0, 0, 0, 0);
    step("br_tgt");
    chk("br_tgt.ins_const", instr_o, 32'h1000_0005);

    // Jump out of IF/ID: word at 4 is 0x0800_0003, so the target is 0xC.
    mem[1] = 32'h0800_0003;
    set_in(1, 32'h4, 0, 0); step("to4");
    set_in(0, 0, 0, 0);     step("fetch4");
    set_in(0, 0, 1, 0);     step("jump");
    chk("jump.pc_const", pc_addr_o, 32'hC);
    set_in(0, 0, 0, 0);     step("jump_tgt");
    chk("jump_tgt.ins_const", instr_o, 32'h1000_0003);
    mem[1] = 32'h1000_0001;

    // Misaligned branch target.
    set_in(1, 32'h16, 0, 0); step("misal");
    chk("misal.err_const", {31'b0, addr_err_o}, 32'd1);

    // Out-of-range branch target.
    mid_reset("rst3");
    set_in(1, 32'h80, 0, 0); step("oor");
    chk("oor.pc_const", pc_addr_o, 32'h80);

    // Sequential fetch running off the end of memory.
    mid_reset("rst4");
    set_in(1, 32'h7C, 0, 0); step("last");
    set_in(0, 0, 0, 0);      step("past"); step("past2");

    // PC wrap modulo 2^32.
    mid_reset("rst5");
    set_in(1, 32'hFFFF_FFFC, 0, 0); step("top");
    set_in(0, 0, 0, 0);             step("wrap");
    chk("wrap.pc_const", pc_addr_o, 32'h0);

    // Randomized traffic with periodic mid-stream resets.
    for (int k = 0; k < 64; k++)
      mem[k] = ($urandom & 32'hFC00_0000) | 32'($urandom_range(0, 40));
    mid_reset("rst_rand");
    for (int c = 0; c < 400; c++) begin
      logic [31:0] bt;
      bt = 32'($urandom_range(0, 40)) * 4;
      if ($urandom_range(0, 9) == 0) bt[1:0] = 2'($urandom_range(1, 3));
      set_in($urandom_range(0, 9) == 0, bt, $urandom_range(0, 9) == 0,
             $urandom_range(0, 3) == 0);
      step("rand");
      if (c % 80 == 79) mid_reset("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
